// File: rtl/nn_pkg.sv
// Shared definitions for the fixed-point neural-network pipeline stages.
// Holds datapath widths, the controller state type and the output clamp.
package nn_pkg;

    localparam int DATA_W    = 16;
    localparam int ACC_W     = 40;
    localparam int FRAC_BITS = 8;

    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(32767);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_X,
        ST_MAC,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Rescale, saturate and rectify; the negative clamp and ReLU collapse to zero.
    function automatic logic [DATA_W-1:0] sat_relu(input logic signed [ACC_W-1:0] acc,
                                                   input int unsigned frac);
        logic signed [ACC_W-1:0] s;
        s = acc >>> frac;
        if (s[ACC_W-1])
            return '0;
        else if (s > Q_MAX)
            return 16'h7FFF;
        else
            return s[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: 16x16 signed products summed into a 40-bit
// accumulator, with a rescaled/saturated/rectified output register.
module mac_lane
    import nn_pkg::*;
#(
    parameter int FRAC_BITS = 8
) (
    input  logic                     clock,
    input  logic                     clear_n,
    input  logic                     acc_en,
    input  logic                     last,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic        [DATA_W-1:0] z
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    sum;

    assign prod = x * w;
    assign sum  = acc + $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});

    // z is captured from the final sum so it is already valid during the EMIT strobe.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            acc <= '0;
            z   <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= sum;
            if (last)
                z <= sat_relu(sum, FRAC_BITS);
        end
    end

endmodule

// File: rtl/first_stage.sv
// Hidden-layer stage: z = ReLU(W*x) in Q8.8, four neurons computed in parallel.
// Caches x, streams 4-lane weight words through the MAC lanes, strobes each row.
module first_stage
    import nn_pkg::*;
#(
    parameter int N_IN      = 16,
    parameter int N_ROWS    = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic                clock,
    input  logic                clear_n,
    input  logic                en,
    input  logic                start,
    input  logic [DATA_W-1:0]   x_element,
    input  logic                x_element_ready,
    output logic                w_element_requested,
    input  logic                w_element_ready,
    input  logic [4*DATA_W-1:0] w_elements,
    output logic [DATA_W-1:0]   z0_element,
    output logic [DATA_W-1:0]   z1_element,
    output logic [DATA_W-1:0]   z2_element,
    output logic [DATA_W-1:0]   z3_element,
    output logic                z0_element_ready,
    output logic                z1_element_ready,
    output logic                z2_element_ready,
    output logic                z3_element_ready,
    output logic                busy,
    output logic                finished
);

    localparam int CW = (N_IN   > 1) ? $clog2(N_IN)   : 1;
    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    state_t state, state_nx;

    logic [CW-1:0]            x_cnt;
    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic signed [DATA_W-1:0] x_cache [N_IN];
    logic [DATA_W-1:0]        z_bus   [4];

    logic x_take, w_take, emit_go;
    logic last_x, last_col, last_row;

    assign x_take              = en && (state == ST_LOAD_X) && x_element_ready;
    assign w_element_requested = en && (state == ST_MAC);
    assign w_take              = w_element_requested && w_element_ready;
    assign emit_go             = en && (state == ST_EMIT);

    assign last_x   = (x_cnt == CW'(N_IN - 1));
    assign last_col = (col   == CW'(N_IN - 1));
    assign last_row = (row   == RW'(N_ROWS - 1));

    always_comb begin
        state_nx = state;
        if (en) begin
            case (state)
                ST_IDLE,
                ST_DONE:   if (start) state_nx = ST_LOAD_X;
                ST_LOAD_X: if (x_take && last_x) state_nx = ST_MAC;
                ST_MAC:    if (w_take && last_col) state_nx = ST_EMIT;
                ST_EMIT:   state_nx = last_row ? ST_DONE : ST_MAC;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_IDLE;
            x_cnt <= '0;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nx;
            if (x_take)
                x_cnt <= last_x ? '0 : x_cnt + 1'b1;
            if (w_take)
                col <= last_col ? '0 : col + 1'b1;
            if (emit_go)
                row <= last_row ? '0 : row + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (x_take)
            x_cache[x_cnt] <= x_element;
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        mac_lane #(
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .clock   (clock),
            .clear_n (clear_n),
            .acc_en  (w_take),
            .last    (last_col),
            .clr     (emit_go),
            .x       (x_cache[col]),
            .w       (w_elements[DATA_W*k +: DATA_W]),
            .z       (z_bus[k])
        );
    end

    assign z0_element = z_bus[0];
    assign z1_element = z_bus[1];
    assign z2_element = z_bus[2];
    assign z3_element = z_bus[3];

    assign z0_element_ready = (state == ST_EMIT);
    assign z1_element_ready = (state == ST_EMIT);
    assign z2_element_ready = (state == ST_EMIT);
    assign z3_element_ready = (state == ST_EMIT);

    assign busy     = (state == ST_LOAD_X) || (state == ST_MAC) || (state == ST_EMIT);
    assign finished = (state == ST_DONE);

endmodule
